// File: rtl/fetch_entry_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_entry_queue
// Brief    : Realigns 32-bit I$ words into RVC/RV instructions (including
//            instructions straddling two words) and buffers them in a small
//            FIFO presented to decode under a valid/ready handshake.
//            Optional macro FETCH_QUEUE_BYPASS_EN: when defined, the first
//            entry of an incoming word is forwarded to decode in the same
//            cycle while the FIFO is empty.
//            fetch_entry_o is the flattened fetch_entry_t, MSB first:
//              [288:225] address      [224:193] instruction
//              [192:129] branch_predict (always zero)
//              [128:65]  ex.cause     [64:1]    ex.tval    [0] ex.valid
// Revision : 1.0 - initial release
// ============================================================================
module fetch_entry_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         fetch_valid_i,
  output logic         fetch_ready_o,
  input  logic [63:0]  fetch_addr_i,
  input  logic [31:0]  fetch_data_i,
  input  logic         fetch_ex_valid_i,
  output logic [288:0] fetch_entry_o,
  output logic         fetch_entry_valid_o,
  input  logic         fetch_entry_ready_i
);

  localparam int C_PTR_W   = $clog2(DEPTH);
  localparam int C_CNT_W   = C_PTR_W + 1;
  localparam int C_BP_W    = 64;
  localparam int C_ENTRY_W = 64 + 32 + C_BP_W + 64 + 64 + 1;

  localparam logic [63:0]        C_INSTR_ACCESS_FAULT = 64'd1;
  localparam logic [C_PTR_W-1:0] C_PTR_ONE            = C_PTR_W'(1);
  localparam logic [C_CNT_W-1:0] C_READY_MAX          = C_CNT_W'(DEPTH - 2);

  // Pack one fetch entry; the exception cause is only meaningful with ex.valid.
  function automatic logic [C_ENTRY_W-1:0] f_make_entry(
    input logic [63:0] addr,
    input logic [31:0] instr,
    input logic        exv,
    input logic [63:0] tval
  );
    return {addr, instr, {C_BP_W{1'b0}},
            (exv ? C_INSTR_ACCESS_FAULT : 64'h0), tval, exv};
  endfunction

  // FIFO storage and bookkeeping
  logic [C_ENTRY_W-1:0] r_mem [DEPTH];
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_CNT_W-1:0]   r_count;

  // Realign state: lower half of a 32-bit instruction waiting for its upper half
  logic                 r_pend_valid;
  logic [15:0]          r_pend_half;
  logic [63:0]          r_pend_addr;

  logic                 w_accept;
  logic                 w_pop;
  logic [15:0]          w_lower;
  logic [15:0]          w_upper;
  logic [63:0]          w_upper_addr;
  logic                 w_upper_comp;
  logic [C_ENTRY_W-1:0] w_upper_entry;

  logic                 w_p0_v;
  logic                 w_p1_v;
  logic [C_ENTRY_W-1:0] w_p0;
  logic [C_ENTRY_W-1:0] w_p1;
  logic                 w_pend_set;
  logic [15:0]          w_pend_half_n;
  logic [63:0]          w_pend_addr_n;

  logic                 w_byp;
  logic                 w_byp_taken;
  logic                 w_wa_v;
  logic                 w_wb_v;
  logic [C_ENTRY_W-1:0] w_wa;
  logic [C_ENTRY_W-1:0] w_wb;
  logic [C_CNT_W-1:0]   w_n_wr;
  logic [C_PTR_W-1:0]   w_wr_ptr1;

  // Ready needs two free slots so any word (0..2 pushes) always fits.
  assign fetch_ready_o = !flush_i && (r_count <= C_READY_MAX);
  assign w_accept      = fetch_valid_i && fetch_ready_o;
  assign w_pop         = (r_count != '0) && fetch_entry_ready_i;

  assign w_lower       = fetch_data_i[15:0];
  assign w_upper       = fetch_data_i[31:16];
  // Upper half always sits at word base + 2, whether or not A[1] is set.
  assign w_upper_addr  = {fetch_addr_i[63:2], 2'b10};
  assign w_upper_comp  = (w_upper[1:0] != 2'b11);
  assign w_upper_entry = f_make_entry(w_upper_addr, {16'h0, w_upper}, 1'b0, 64'h0);

  // Realigner: split the incoming word into up to two entries in program order.
  always_comb begin
    w_p0_v        = 1'b0;
    w_p1_v        = 1'b0;
    w_p0          = '0;
    w_p1          = '0;
    w_pend_set    = 1'b0;
    w_pend_half_n = w_upper;
    w_pend_addr_n = w_upper_addr;
    if (fetch_ex_valid_i) begin
      // A faulting word yields one fault entry; the straddled half is abandoned.
      w_p0_v = 1'b1;
      w_p0   = f_make_entry(r_pend_valid ? r_pend_addr : fetch_addr_i,
                            32'h0, 1'b1, fetch_addr_i);
    end else if (fetch_addr_i[1]) begin
      // Jump target in the upper half: any pending half belongs to a dead path.
      w_p0_v     = w_upper_comp;
      w_p0       = w_upper_entry;
      w_pend_set = !w_upper_comp;
    end else begin
      if (r_pend_valid) begin
        w_p0_v = 1'b1;
        w_p0   = f_make_entry(r_pend_addr, {w_lower, r_pend_half}, 1'b0, 64'h0);
      end else if (w_lower[1:0] != 2'b11) begin
        w_p0_v = 1'b1;
        w_p0   = f_make_entry(fetch_addr_i, {16'h0, w_lower}, 1'b0, 64'h0);
      end else begin
        w_p0_v = 1'b1;
        w_p0   = f_make_entry(fetch_addr_i, fetch_data_i, 1'b0, 64'h0);
      end
      // Upper half still to process unless a full 32-bit word was just consumed.
      if (r_pend_valid || (w_lower[1:0] != 2'b11)) begin
        w_p1_v     = w_upper_comp;
        w_p1       = w_upper_entry;
        w_pend_set = !w_upper_comp;
      end
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = (r_count == '0) && w_accept && w_p0_v;
`else
  assign w_byp = 1'b0;
`endif
  assign w_byp_taken = w_byp && fetch_entry_ready_i;

  // Select what gets written: a bypassed first entry skips the FIFO.
  always_comb begin
    w_wa   = w_p0;
    w_wa_v = w_accept && w_p0_v;
    w_wb   = w_p1;
    w_wb_v = w_accept && w_p1_v;
    if (w_byp_taken) begin
      w_wa   = w_p1;
      w_wa_v = w_p1_v;
      w_wb_v = 1'b0;
    end
  end

  assign w_n_wr    = C_CNT_W'(w_wa_v) + C_CNT_W'(w_wb_v);
  assign w_wr_ptr1 = r_wr_ptr + C_PTR_ONE;

  // Head presentation: bypass entry if active, otherwise FIFO head or zero.
  always_comb begin
    fetch_entry_valid_o = (r_count != '0);
    fetch_entry_o       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    if (w_byp) begin
      fetch_entry_valid_o = 1'b1;
      fetch_entry_o       = w_p0;
    end
  end

  // Storage writes; contents are don't-care until the count covers them.
  always_ff @(posedge clk_i) begin
    if (w_wa_v) r_mem[r_wr_ptr]  <= w_wa;
    if (w_wb_v) r_mem[w_wr_ptr1] <= w_wb;
  end

  // Pointers, occupancy and realign state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_half  <= '0;
      r_pend_addr  <= '0;
    end else if (flush_i) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + C_PTR_W'(w_n_wr);
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_count  <= r_count + w_n_wr - C_CNT_W'(w_pop);
      if (w_accept) begin
        r_pend_valid <= w_pend_set;
        if (w_pend_set) begin
          r_pend_half <= w_pend_half_n;
          r_pend_addr <= w_pend_addr_n;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_entry_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_entry_queue
// Brief    : Directed self-checking bench for fetch_entry_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_entry_queue;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         fetch_valid_i = 1'b0;
  logic         fetch_ready_o;
  logic [63:0]  fetch_addr_i = '0;
  logic [31:0]  fetch_data_i = '0;
  logic         fetch_ex_valid_i = 1'b0;
  logic [288:0] fetch_entry_o;
  logic         fetch_entry_valid_o;
  logic         fetch_entry_ready_i = 1'b0;

  int errors = 0;
  int checks = 0;

  wire [63:0] e_addr  = fetch_entry_o[288:225];
  wire [31:0] e_instr = fetch_entry_o[224:193];
  wire [63:0] e_bp    = fetch_entry_o[192:129];
  wire [63:0] e_cause = fetch_entry_o[128:65];
  wire [63:0] e_tval  = fetch_entry_o[64:1];
  wire        e_exv   = fetch_entry_o[0];

  fetch_entry_queue #(.DEPTH(4)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_addr_i        (fetch_addr_i),
    .fetch_data_i        (fetch_data_i),
    .fetch_ex_valid_i    (fetch_ex_valid_i),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_entry_ready_i (fetch_entry_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one word, waiting (bounded) for ready; returns after the accept edge.
  task automatic send(input logic [63:0] addr, input logic [31:0] data, input logic ex);
    int n = 0;
    while (!fetch_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("send_ready_timeout", 64'(fetch_ready_o), 64'd1);
    fetch_addr_i     = addr;
    fetch_data_i     = data;
    fetch_ex_valid_i = ex;
    fetch_valid_i    = 1'b1;
    tick();
    fetch_valid_i    = 1'b0;
    fetch_ex_valid_i = 1'b0;
  endtask

  // Check the head entry, then accept it with a one-cycle ready pulse.
  task automatic pop_expect(input string tag, input logic [63:0] addr, input logic [31:0] instr);
    check({tag, "_valid"}, 64'(fetch_entry_valid_o), 64'd1);
    check({tag, "_addr"},  e_addr, addr);
    check({tag, "_instr"}, 64'(e_instr), 64'(instr));
    check({tag, "_exv"},   64'(e_exv), 64'd0);
    fetch_entry_ready_i = 1'b1;
    tick();
    fetch_entry_ready_i = 1'b0;
    #1;
  endtask

  initial begin
    #12;
    check("rst_valid", 64'(fetch_entry_valid_o), 64'd0);
    check("rst_ready", 64'(fetch_ready_o), 64'd1);
    check("rst_entry_zero", 64'(|fetch_entry_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Two compressed halves, decode ready held high
    fetch_entry_ready_i = 1'b1;
    send(64'h1000, 32'h4505_4501, 1'b0);
    check("c2_a_valid", 64'(fetch_entry_valid_o), 64'd1);
    check("c2_a_addr", e_addr, 64'h1000);
    check("c2_a_instr", 64'(e_instr), 64'h4501);
    check("c2_bp_zero", e_bp, 64'h0);
    tick();
    check("c2_b_addr", e_addr, 64'h1002);
    check("c2_b_instr", 64'(e_instr), 64'h4505);
    tick();
    check("c2_empty", 64'(fetch_entry_valid_o), 64'd0);
    fetch_entry_ready_i = 1'b0;

    // Straddling 32-bit instruction
    send(64'h2000, 32'h0513_4501, 1'b0);
    send(64'h2004, 32'h0000_0000, 1'b0);
    pop_expect("st0", 64'h2000, 32'h0000_4501);
    pop_expect("st1", 64'h2002, 32'h0000_0513);
    pop_expect("st2", 64'h2006, 32'h0000_0000);
    check("st_empty", 64'(fetch_entry_valid_o), 64'd0);
    send(64'h2008, 32'h4505_4501, 1'b0);
    pop_expect("st_clr0", 64'h2008, 32'h0000_4501);
    pop_expect("st_clr1", 64'h200A, 32'h0000_4505);

    // Misaligned start: lower half ignored
    send(64'h3002, 32'h4505_0093, 1'b0);
    pop_expect("mis", 64'h3002, 32'h0000_4505);
    check("mis_empty", 64'(fetch_entry_valid_o), 64'd0);

    // Backpressure and pointer wrap
    send(64'h6000, 32'h0010_0013, 1'b0);
    send(64'h6004, 32'h0020_0013, 1'b0);
    check("bp_ready_cnt2", 64'(fetch_ready_o), 64'd1);
    send(64'h6008, 32'h0030_0013, 1'b0);
    check("bp_ready_cnt3", 64'(fetch_ready_o), 64'd0);
    fetch_entry_ready_i = 1'b1;
    #1;
    check("bp_ready_pop_cycle", 64'(fetch_ready_o), 64'd0);
    check("bp_head0", e_addr, 64'h6000);
    check("bp_head0_instr", 64'(e_instr), 64'h0010_0013);
    tick();
    fetch_entry_ready_i = 1'b0;
    check("bp_ready_after_pop", 64'(fetch_ready_o), 64'd1);
    send(64'h600C, 32'h0040_0013, 1'b0);
    pop_expect("bp1", 64'h6004, 32'h0020_0013);
    pop_expect("bp2", 64'h6008, 32'h0030_0013);
    pop_expect("bp3", 64'h600C, 32'h0040_0013);
    check("bp_empty", 64'(fetch_entry_valid_o), 64'd0);

    // Fault with a pending half
    send(64'h4004, 32'h0013_4501, 1'b0);
    pop_expect("flt_pre", 64'h4004, 32'h0000_4501);
    send(64'h4008, 32'hDEAD_BEEF, 1'b1);
    check("flt_valid", 64'(fetch_entry_valid_o), 64'd1);
    check("flt_addr", e_addr, 64'h4006);
    check("flt_instr", 64'(e_instr), 64'h0);
    check("flt_exv", 64'(e_exv), 64'd1);
    check("flt_tval", e_tval, 64'h4008);
    check("flt_cause", e_cause, 64'd1);
    fetch_entry_ready_i = 1'b1;
    tick();
    fetch_entry_ready_i = 1'b0;
    check("flt_single", 64'(fetch_entry_valid_o), 64'd0);

    // Flush with buffered entries and a pending half
    send(64'h5100, 32'h4505_4501, 1'b0);
    send(64'h5104, 32'h0013_4501, 1'b0);
    check("fl_pre_valid", 64'(fetch_entry_valid_o), 64'd1);
    check("fl_pre_ready", 64'(fetch_ready_o), 64'd0);
    flush_i = 1'b1;
    #1;
    check("fl_ready_during", 64'(fetch_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    #1;
    check("fl_valid_after", 64'(fetch_entry_valid_o), 64'd0);
    check("fl_ready_after", 64'(fetch_ready_o), 64'd1);
    send(64'h5000, 32'h4505_4501, 1'b0);
    pop_expect("fl_new0", 64'h5000, 32'h0000_4501);
    pop_expect("fl_new1", 64'h5002, 32'h0000_4505);
    check("fl_end_empty", 64'(fetch_entry_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
